// File: rtl/exec_pkg.sv
// Shared definitions for the execution-engine instruction issuer.
// Holds opcodes, word field positions, the issue FSM states and the word encoder.
package exec_pkg;

  localparam logic [3:0] OP_STOP = 4'd0;
  localparam logic [3:0] OP_SUM  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_SCA  = 4'd4;
  localparam logic [3:0] OP_TRA  = 4'd5;

  localparam int OPC_LSB      = 28;
  localparam int DSEL_LSB     = 26;
  localparam int DST_LSB      = 18;
  localparam int SRC1_MEM_BIT = 17;
  localparam int SRC1_LSB     = 9;
  localparam int SRC2_MEM_BIT = 8;
  localparam int SRC2_LSB     = 0;

  localparam int DONE_ADD  = 0;
  localparam int DONE_SUB  = 1;
  localparam int DONE_MULT = 2;
  localparam int DONE_TRAN = 3;
  localparam int DONE_MEM  = 4;

  typedef logic [31:0] instr_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_HALT
  } issue_state_t;

  function automatic instr_word_t encode_instr(
    input logic [3:0] opcode,
    input logic [1:0] dst_sel,
    input logic [7:0] dst_addr,
    input logic       src1_mem,
    input logic [7:0] src1_addr,
    input logic       src2_mem,
    input logic [7:0] src2_addr,
    input logic [7:0] scalar
  );
    instr_word_t w;
    w = '0;
    w[OPC_LSB +: 4] = opcode;
    // STOP carries nothing but its opcode; SCA reuses the src1 address slot for the scalar
    if (opcode != OP_STOP) begin
      w[DSEL_LSB +: 2] = dst_sel;
      w[DST_LSB +: 8]  = dst_addr;
      if (opcode == OP_SCA) begin
        w[SRC1_LSB +: 8] = scalar;
      end else begin
        w[SRC1_MEM_BIT]  = src1_mem;
        w[SRC1_LSB +: 8] = src1_addr;
        w[SRC2_MEM_BIT]  = src2_mem;
        w[SRC2_LSB +: 8] = src2_addr;
      end
    end
    return w;
  endfunction

  function automatic logic [4:0] done_mask(input logic [3:0] opcode, input logic dst_mem);
    logic [4:0] m;
    m = '0;
    case (opcode)
      OP_SUM:         m[DONE_ADD]  = 1'b1;
      OP_SUB:         m[DONE_SUB]  = 1'b1;
      OP_MUL, OP_SCA: m[DONE_MULT] = 1'b1;
      OP_TRA:         m[DONE_TRAN] = 1'b1;
      default:        m = '0;
    endcase
    if (dst_mem) m[DONE_MEM] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// Engine-side instruction bus: encoded word, valid/ack handshake and unit done pulses.
interface instr_issue_unit_if;
  logic [255:0] instrBus;
  logic         instr_valid;
  logic         instr_ack;
  logic [4:0]   unit_done;

  modport master (output instrBus, output instr_valid, input instr_ack, input unit_done);
  modport slave  (input instrBus, input instr_valid, output instr_ack, output unit_done);
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap naturally.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Reset only flushes the pointers; stale storage is never read while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Buffers host instructions, encodes them and issues one at a time to the engine.
// Optional macro ISSUE_TIMEOUT_EN adds a WAIT_DONE timeout and the timeout_err port.
module instr_issue_unit
  import exec_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_opcode,
  input  logic [1:0]                    in_dst_sel,
  input  logic [7:0]                    in_dst_addr,
  input  logic                          in_src1_mem,
  input  logic [7:0]                    in_src1_addr,
  input  logic                          in_src2_mem,
  input  logic [7:0]                    in_src2_addr,
  input  logic [7:0]                    in_scalar,
  instr_issue_unit_if.master            eng,
  output logic                          busy,
  output logic                          halted,
  output logic                          err_opcode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef ISSUE_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("instr_issue_unit: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
  end

  issue_state_t state;
  instr_word_t  word_q;
  instr_word_t  head_word;
  instr_word_t  new_word;
  logic         valid_q;
  logic         ready_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         accept;
  logic         opcode_ok;
  logic         push;
  logic         pop;
  logic [4:0]   req_mask;
  logic [4:0]   seen_mask;
  logic [4:0]   done_seen;

`ifdef ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer;
`endif

  assign in_ready  = ready_q && !fifo_full && !halted;
  assign accept    = in_valid && in_ready;
  assign opcode_ok = (in_opcode <= OP_TRA);
  assign push      = accept && opcode_ok;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign new_word  = encode_instr(in_opcode, in_dst_sel, in_dst_addr, in_src1_mem,
                                  in_src1_addr, in_src2_mem, in_src2_addr, in_scalar);
  assign done_seen = seen_mask | (eng.unit_done & req_mask);
  assign busy      = !fifo_empty || (state != ST_IDLE);

  assign eng.instrBus    = {224'b0, word_q};
  assign eng.instr_valid = valid_q;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (new_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ready_q keeps in_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      err_opcode <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept && !opcode_ok) err_opcode <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      valid_q   <= 1'b0;
      halted    <= 1'b0;
      req_mask  <= '0;
      seen_mask <= '0;
`ifdef ISSUE_TIMEOUT_EN
      timer       <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            word_q  <= head_word;
            valid_q <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // done pulses seen here belong to nothing yet, so tracking starts clean
          if (eng.instr_ack) begin
            valid_q <= 1'b0;
            if (word_q[OPC_LSB +: 4] == OP_STOP) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state     <= ST_WAIT_DONE;
              req_mask  <= done_mask(word_q[OPC_LSB +: 4], word_q[DSEL_LSB + 1]);
              seen_mask <= '0;
`ifdef ISSUE_TIMEOUT_EN
              timer     <= '0;
`endif
            end
          end
        end
        ST_WAIT_DONE: begin
          seen_mask <= done_seen;
          if (done_seen == req_mask) begin
            state <= ST_IDLE;
          end
`ifdef ISSUE_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            state       <= ST_IDLE;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
`endif
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed self-checking bench for instr_issue_unit; the timeout step runs only with ISSUE_TIMEOUT_EN.
module tb_instr_issue_unit;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [1:0] in_dst_sel;
  logic [7:0] in_dst_addr;
  logic       in_src1_mem;
  logic [7:0] in_src1_addr;
  logic       in_src2_mem;
  logic [7:0] in_src2_addr;
  logic [7:0] in_scalar;
  logic       busy;
  logic       halted;
  logic       err_opcode;
  logic [2:0] fifo_count;
`ifdef ISSUE_TIMEOUT_EN
  logic       timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0]  t_op   [5] = '{OP_SUB, OP_MUL, OP_TRA, OP_SUM, OP_SCA};
  logic [1:0]  t_dsel [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
  logic [7:0]  t_dst  [5] = '{8'h10, 8'h01, 8'hFF, 8'h80, 8'h00};
  logic        t_s1m  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0]  t_s1a  [5] = '{8'h20, 8'h0F, 8'h00, 8'h80, 8'h00};
  logic        t_s2m  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0]  t_s2a  [5] = '{8'h30, 8'hFF, 8'h00, 8'h01, 8'h00};
  logic [7:0]  t_sc   [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
  logic [31:0] t_word [5] = '{32'h2040_4030, 32'h3806_1FFF, 32'h57FC_0000, 32'h1E03_0001, 32'h4001_FE00};
  logic [4:0]  t_done [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b00001, 5'b00100};
  logic        t_mem  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  instr_issue_unit_if eng();

  instr_issue_unit #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_dst_sel   (in_dst_sel),
    .in_dst_addr  (in_dst_addr),
    .in_src1_mem  (in_src1_mem),
    .in_src1_addr (in_src1_addr),
    .in_src2_mem  (in_src2_mem),
    .in_src2_addr (in_src2_addr),
    .in_scalar    (in_scalar),
    .eng          (eng),
    .busy         (busy),
    .halted       (halted),
    .err_opcode   (err_opcode),
    .fifo_count   (fifo_count)
`ifdef ISSUE_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] dsel, input logic [7:0] dst,
                               input logic s1m, input logic [7:0] s1a, input logic s2m,
                               input logic [7:0] s2a, input logic [7:0] sc);
    in_opcode    = op;
    in_dst_sel   = dsel;
    in_dst_addr  = dst;
    in_src1_mem  = s1m;
    in_src1_addr = s1a;
    in_src2_mem  = s2m;
    in_src2_addr = s2a;
    in_scalar    = sc;
    in_valid     = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    applyStimulus(4'd0, 2'd0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    in_valid = 1'b0;
    eng.instr_ack = 1'b0;
    eng.unit_done = 5'd0;
    step();
    step();

    // Reset state
    checkOutput("rst_instr_valid", 32'(eng.instr_valid), 32'd0);
    checkOutput("rst_instrBus", eng.instrBus[31:0], 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_err_opcode", 32'(err_opcode), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
`ifdef ISSUE_TIMEOUT_EN
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    // SUM issue, ack and done
    $display("[TB] SUM issue");
    applyStimulus(OP_SUM, 2'd0, 8'h05, 1'b0, 8'h01, 1'b1, 8'h02, 8'h00);
    step();
    in_valid = 1'b0;
    checkOutput("sum_count_after_push", 32'(fifo_count), 32'd1);
    checkOutput("sum_not_valid_yet", 32'(eng.instr_valid), 32'd0);
    step();
    checkOutput("sum_valid", 32'(eng.instr_valid), 32'd1);
    checkOutput("sum_word", eng.instrBus[31:0], 32'h1014_0302);
    checkOutput("sum_upper_zero", 32'(|eng.instrBus[255:32]), 32'd0);
    checkOutput("sum_count_after_pop", 32'(fifo_count), 32'd0);
    step();
    checkOutput("sum_valid_held", 32'(eng.instr_valid), 32'd1);
    eng.instr_ack = 1'b1;
    step();
    eng.instr_ack = 1'b0;
    checkOutput("sum_valid_dropped", 32'(eng.instr_valid), 32'd0);
    checkOutput("sum_busy_waiting", 32'(busy), 32'd1);
    eng.unit_done = 5'b00001;
    step();
    eng.unit_done = 5'd0;
    checkOutput("sum_busy_done", 32'(busy), 32'd0);

    // SCA waits for the mult done, not the add done
    $display("[TB] SCA issue");
    applyStimulus(OP_SCA, 2'd0, 8'h03, 1'b1, 8'hAA, 1'b1, 8'h55, 8'h7F);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("sca_word", eng.instrBus[31:0], 32'h400C_FE00);
    eng.instr_ack = 1'b1;
    step();
    eng.instr_ack = 1'b0;
    eng.unit_done = 5'b00001;
    step();
    eng.unit_done = 5'd0;
    step();
    checkOutput("sca_wrong_done_ignored", 32'(busy), 32'd1);
    eng.unit_done = 5'b00100;
    step();
    eng.unit_done = 5'd0;
    checkOutput("sca_released", 32'(busy), 32'd0);

    // Fill the FIFO without acking, then drain in order
    $display("[TB] FIFO fill and drain");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(t_op[k], t_dsel[k], t_dst[k], t_s1m[k], t_s1a[k], t_s2m[k], t_s2a[k], t_sc[k]);
      step();
    end
    in_valid = 1'b0;
    checkOutput("fill_count", 32'(fifo_count), 32'd4);
    checkOutput("fill_in_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(OP_SUM, 2'd0, 8'h11, 1'b0, 8'h22, 1'b0, 8'h33, 8'h00);
    step();
    in_valid = 1'b0;
    checkOutput("fill_blocked_push", 32'(fifo_count), 32'd4);
    for (int k = 0; k < 5; k++) begin
      checkOutput("drain_valid", 32'(eng.instr_valid), 32'd1);
      checkOutput("drain_word", eng.instrBus[31:0], t_word[k]);
      checkOutput("drain_count", 32'(fifo_count), 32'(4 - k));
      eng.instr_ack = 1'b1;
      eng.unit_done = t_done[k] | (t_mem[k] ? 5'b10000 : 5'b00000);
      step();
      eng.instr_ack = 1'b0;
      eng.unit_done = 5'd0;
      step();
      step();
      checkOutput("done_with_ack_ignored_valid", 32'(eng.instr_valid), 32'd0);
      checkOutput("done_with_ack_ignored_count", 32'(fifo_count), 32'(4 - k));
      if (t_mem[k]) begin
        eng.unit_done = 5'b10000;
        step();
        eng.unit_done = 5'd0;
        step();
        step();
        checkOutput("mem_only_not_released", 32'(fifo_count), 32'(4 - k));
      end
      eng.unit_done = t_done[k];
      step();
      eng.unit_done = 5'd0;
      step();
    end
    checkOutput("drain_busy_clear", 32'(busy), 32'd0);
    checkOutput("drain_count_zero", 32'(fifo_count), 32'd0);

    // STOP halts issue and retains the following entry
    $display("[TB] STOP handling");
    applyStimulus(OP_STOP, 2'd3, 8'hAA, 1'b1, 8'h55, 1'b1, 8'h33, 8'h77);
    step();
    applyStimulus(OP_MUL, 2'd0, 8'h01, 1'b0, 8'h02, 1'b0, 8'h03, 8'h00);
    step();
    in_valid = 1'b0;
    checkOutput("stop_valid", 32'(eng.instr_valid), 32'd1);
    checkOutput("stop_word", eng.instrBus[31:0], 32'h0000_0000);
    eng.instr_ack = 1'b1;
    step();
    eng.instr_ack = 1'b0;
    checkOutput("stop_halted", 32'(halted), 32'd1);
    checkOutput("stop_valid_low", 32'(eng.instr_valid), 32'd0);
    checkOutput("stop_count", 32'(fifo_count), 32'd1);
    checkOutput("stop_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(OP_SUM, 2'd0, 8'h01, 1'b0, 8'h01, 1'b0, 8'h01, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("halt_count_kept", 32'(fifo_count), 32'd1);
    checkOutput("halt_no_issue", 32'(eng.instr_valid), 32'd0);

    // Bad opcode, then asynchronous reset in the middle of ISSUE
    $display("[TB] bad opcode and async reset");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checkOutput("rst2_halted", 32'(halted), 32'd0);
    checkOutput("rst2_count", 32'(fifo_count), 32'd0);
    applyStimulus(4'h9, 2'd0, 8'h01, 1'b0, 8'h01, 1'b0, 8'h01, 8'h00);
    step();
    in_valid = 1'b0;
    checkOutput("bad_op_err", 32'(err_opcode), 32'd1);
    checkOutput("bad_op_count", 32'(fifo_count), 32'd0);
    checkOutput("bad_op_ready", 32'(in_ready), 32'd1);
    checkOutput("bad_op_not_busy", 32'(busy), 32'd0);
    applyStimulus(OP_SUB, 2'd0, 8'h02, 1'b0, 8'h03, 1'b0, 8'h04, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("mid_issue_valid", 32'(eng.instr_valid), 32'd1);
    checkOutput("err_sticky", 32'(err_opcode), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(eng.instr_valid), 32'd0);
    checkOutput("async_rst_err", 32'(err_opcode), 32'd0);
    checkOutput("async_rst_bus", eng.instrBus[31:0], 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef ISSUE_TIMEOUT_EN
    // TRA with the done flag withheld
    $display("[TB] timeout");
    applyStimulus(OP_TRA, 2'd0, 8'h01, 1'b0, 8'h02, 1'b0, 8'h03, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("to_valid", 32'(eng.instr_valid), 32'd1);
    eng.instr_ack = 1'b1;
    step();
    eng.instr_ack = 1'b0;
    repeat (7) step();
    checkOutput("to_not_yet", 32'(timeout_err), 32'd0);
    checkOutput("to_still_busy", 32'(busy), 32'd1);
    step();
    checkOutput("to_err", 32'(timeout_err), 32'd1);
    checkOutput("to_idle", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
